// File: rtl/mat_stream_engine_if.sv
// Bus bundle for mat_stream_engine: run control, operand reads, functional-unit
// handoff and result writes. The engine is the master; memories/FU/host are the slave.
interface mat_stream_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 11
);
    localparam int WORD_W = LANES * DATA_WIDTH;

    logic                  start;
    logic [2:0]            op_code;
    logic [ADDR_WIDTH-1:0] num_words;
    logic [DATA_WIDTH-1:0] scalar;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WORD_W-1:0]     a_rdata;
    logic [WORD_W-1:0]     b_rdata;

    logic                  fu_valid;
    logic                  fu_sel;
    logic [WORD_W-1:0]     fu_a;
    logic [WORD_W-1:0]     fu_b;
    logic [WORD_W-1:0]     fu_res;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_W-1:0]     r_wdata;
    logic                  r_ready;

    modport master (
        input  start, op_code, num_words, scalar, a_rdata, b_rdata, fu_res, r_ready,
        output busy, done, err, a_rd_en, b_rd_en, a_addr, b_addr,
               fu_valid, fu_sel, fu_a, fu_b, r_wr_en, r_addr, r_wdata
    );

    modport slave (
        output start, op_code, num_words, scalar, a_rdata, b_rdata, fu_res, r_ready,
        input  busy, done, err, a_rd_en, b_rd_en, a_addr, b_addr,
               fu_valid, fu_sel, fu_a, fu_b, r_wr_en, r_addr, r_wdata
    );
endinterface

// File: rtl/mat_stream_engine.sv
// Streams LANES-wide words from operand memories through an external functional unit
// and writes results back, with a credit-limited result FIFO absorbing write backpressure.
module mat_stream_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int ADD_LAT    = 7,
    parameter int MUL_LAT    = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int A_BASE     = 0,
    parameter int B_BASE     = 512,
    parameter int R_BASE     = 1024
) (
    input logic                 clock,
    input logic                 reset,
    mat_stream_engine_if.master bus
);
    localparam int WORD_W  = LANES * DATA_WIDTH;
    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0]    OP_MAT_ADD   = 3'd1;
    localparam logic [2:0]    OP_SCAL_MUL  = 3'd2;
    localparam logic [2:0]    OP_SCAL_ADD  = 3'd3;
    localparam logic [CW-1:0] DEPTH_CNT    = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(FIFO_DEPTH);

    // The FIFO must hold every result already in the FU pipe when writes stall.
    if (FIFO_DEPTH < MAX_LAT + 2) begin : g_depth_check
        $error("FIFO_DEPTH must be at least max(ADD_LAT, MUL_LAT) + 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [DATA_WIDTH-1:0] scalar_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] issued;
    logic [ADDR_WIDTH-1:0] written;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         count;
    logic                  fu_valid_q;
    logic [MAX_LAT-1:0]    pipe;
    logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic legal_op;
    logic rd_fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign legal_op = (bus.op_code == OP_MAT_ADD) || (bus.op_code == OP_SCAL_MUL) ||
                      (bus.op_code == OP_SCAL_ADD);

    // Credits use registered counts only, so a pop frees its slot one cycle later.
    assign rd_fire = (state == S_RUN) && (issued < num_q) &&
                     (({1'b0, inflight} + {1'b0, count}) < DEPTH_CREDIT);
    assign push    = (op_q == OP_SCAL_MUL) ? pipe[MUL_LAT-1] : pipe[ADD_LAT-1];
    assign pop     = (count != '0) && bus.r_ready;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start && legal_op)
                    state_nxt = (bus.num_words == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (pop && (written + ADDR_WIDTH'(1) == num_q)) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= '0;
            num_q      <= '0;
            scalar_q   <= '0;
            err_q      <= 1'b0;
            issued     <= '0;
            written    <= '0;
            inflight   <= '0;
            count      <= '0;
            fu_valid_q <= 1'b0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            assert (!(push && !pop && count == DEPTH_CNT));
            if (state == S_IDLE && bus.start) begin
                op_q     <= bus.op_code;
                num_q    <= bus.num_words;
                scalar_q <= bus.scalar;
                err_q    <= !legal_op;
                issued   <= '0;
                written  <= '0;
            end
            if (rd_fire) issued  <= issued + ADDR_WIDTH'(1);
            if (pop)     written <= written + ADDR_WIDTH'(1);

            fu_valid_q <= rd_fire;
            pipe       <= (pipe << 1) | MAX_LAT'(fu_valid_q);

            unique case ({rd_fire, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // NOTE: storage is not reset; the zeroed count and pointers make stale entries unreachable.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= bus.fu_res;
    end

    // Addresses and data are forced to zero whenever their strobe is low.
    assign bus.err      = err_q;
    assign bus.a_rd_en  = rd_fire;
    assign bus.b_rd_en  = rd_fire && (op_q == OP_MAT_ADD);
    assign bus.a_addr   = bus.a_rd_en ? ADDR_WIDTH'(A_BASE) + issued : '0;
    assign bus.b_addr   = bus.b_rd_en ? ADDR_WIDTH'(B_BASE) + issued : '0;
    assign bus.fu_valid = fu_valid_q;
    assign bus.fu_sel   = (op_q == OP_SCAL_MUL);
    assign bus.fu_a     = fu_valid_q ? bus.a_rdata : '0;
    assign bus.fu_b     = !fu_valid_q ? '0 :
                          (op_q == OP_MAT_ADD) ? bus.b_rdata : {LANES{scalar_q}};
    assign bus.r_wr_en  = (count != '0);
    assign bus.r_addr   = bus.r_wr_en ? ADDR_WIDTH'(R_BASE) + written : '0;
    assign bus.r_wdata  = bus.r_wr_en ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_mat_stream_engine.sv
// Directed bench for mat_stream_engine: behavioural operand memories and a lane-wise
// integer add/multiply FU with the configured latencies; expectations are hand-derived.
module tb_mat_stream_engine;
    localparam int DW      = 32;
    localparam int LANES   = 8;
    localparam int AW      = 11;
    localparam int ADD_LAT = 7;
    localparam int MUL_LAT = 5;
    localparam int A_BASE  = 0;
    localparam int B_BASE  = 512;
    localparam int R_BASE  = 1024;
    localparam int W       = DW * LANES;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          sel;
        logic [W-1:0]  data;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    int   amem [64];
    int   bmem [64];
    logic [W-1:0] add_d [ADD_LAT];
    logic [W-1:0] mul_d [MUL_LAT];

    ev_t  rd_q [$];
    ev_t  b_q  [$];
    ev_t  fu_q [$];
    ev_t  wr_q [$];
    int   done_q [$];
    int   rd0, b0, f0, w0, d0, s;

    mat_stream_engine_if #(.DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW)) bus ();

    mat_stream_engine #(
        .DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT),
        .FIFO_DEPTH(16), .A_BASE(A_BASE), .B_BASE(B_BASE), .R_BASE(R_BASE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] rep(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return {LANES{t}};
    endfunction

    function automatic logic [W-1:0] fu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic mul);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++)
            r[l*DW +: DW] = mul ? a[l*DW +: DW] * b[l*DW +: DW] : a[l*DW +: DW] + b[l*DW +: DW];
        return r;
    endfunction

    function automatic int mem_word(input int idx, input logic is_b);
        if (idx < 0 || idx > 63) return 0;
        return is_b ? bmem[idx] : amem[idx];
    endfunction

    // Memories answer one cycle after the strobe; the FU returns results LAT cycles after fu_valid.
    assign bus.fu_res = add_d[ADD_LAT-1] | mul_d[MUL_LAT-1];
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < ADD_LAT; k++) add_d[k] <= '0;
            for (int k = 0; k < MUL_LAT; k++) mul_d[k] <= '0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
        end else begin
            for (int k = ADD_LAT - 1; k > 0; k--) add_d[k] <= add_d[k-1];
            for (int k = MUL_LAT - 1; k > 0; k--) mul_d[k] <= mul_d[k-1];
            add_d[0] <= (bus.fu_valid && !bus.fu_sel) ? fu_calc(bus.fu_a, bus.fu_b, 1'b0) : '0;
            mul_d[0] <= (bus.fu_valid &&  bus.fu_sel) ? fu_calc(bus.fu_a, bus.fu_b, 1'b1) : '0;
            if (bus.a_rd_en) bus.a_rdata <= rep(mem_word(int'(bus.a_addr) - A_BASE, 1'b0));
            if (bus.b_rd_en) bus.b_rdata <= rep(mem_word(int'(bus.b_addr) - B_BASE, 1'b1));
        end
    end

    always @(negedge clock) begin
        if (bus.a_rd_en)                rd_q.push_back('{cyc, bus.a_addr, 1'b0, '0});
        if (bus.b_rd_en)                b_q.push_back('{cyc, bus.b_addr, 1'b0, '0});
        if (bus.fu_valid)               fu_q.push_back('{cyc, '0, bus.fu_sel, bus.fu_b});
        if (bus.r_wr_en && bus.r_ready) wr_q.push_back('{cyc, bus.r_addr, 1'b0, bus.r_wdata});
        if (bus.done)                   done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic snap();
        rd0 = rd_q.size();
        b0  = b_q.size();
        f0  = fu_q.size();
        w0  = wr_q.size();
        d0  = done_q.size();
    endtask

    // start is high during cycle s and sampled at the edge that closes it.
    task automatic do_start(input logic [2:0] op, input int nw, input int sc);
        snap();
        bus.op_code   = op;
        bus.num_words = AW'(nw);
        bus.scalar    = DW'(sc);
        bus.start     = 1'b1;
        s = cyc;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int g = 0;
        while (done_q.size() == d0 && g < budget) begin
            @(negedge clock);
            g++;
        end
        check_int({tag, "_done_seen"}, int'(done_q.size() > d0), 1);
        tick(2);
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clock);
        check({tag, "_ctrl"}, W'({bus.busy, bus.done, bus.err, bus.a_rd_en, bus.b_rd_en,
                                  bus.fu_valid, bus.fu_sel, bus.r_wr_en}), '0);
        check({tag, "_addr"}, W'({bus.a_addr, bus.b_addr, bus.r_addr}), '0);
        check({tag, "_fu_a"}, bus.fu_a, '0);
        check({tag, "_fu_b"}, bus.fu_b, '0);
        check({tag, "_wdata"}, bus.r_wdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.start = 1'b0; bus.op_code = '0; bus.num_words = '0; bus.scalar = '0; bus.r_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            amem[i] = i;
            bmem[i] = 10;
        end
        tick(3);
        reset = 1'b0;
        check_all_zero("reset");

        // MAT_ADD, 4 words: results 10..13, writes at cycles 3+LAT..6+LAT, done at 7+LAT.
        tick(1);
        do_start(3'd1, 4, 0);
        wait_done("add4", 100);
        check_int("add4_reads", rd_q.size() - rd0, 4);
        check_int("add4_first_read_cyc", rd_q[rd0].cyc, s + 1);
        check_int("add4_last_read_addr", int'(rd_q[rd0+3].addr), A_BASE + 3);
        check_int("add4_b_reads", b_q.size() - b0, 4);
        check_int("add4_b_addr0", int'(b_q[b0].addr), B_BASE);
        check_int("add4_fu_cyc", fu_q[f0].cyc, s + 2);
        check_int("add4_fu_sel", int'(fu_q[f0].sel), 0);
        check("add4_fu_b", fu_q[f0].data, rep(10));
        check_int("add4_writes", wr_q.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("add4_waddr%0d", i), int'(wr_q[w0+i].addr), R_BASE + i);
            check($sformatf("add4_wdata%0d", i), wr_q[w0+i].data, rep(10 + i));
            check_int($sformatf("add4_wcyc%0d", i), wr_q[w0+i].cyc, s + 3 + ADD_LAT + i);
        end
        check_int("add4_done_cyc", done_q[d0], s + 7 + ADD_LAT);
        check_int("add4_done_pulses", done_q.size() - d0, 1);
        check_int("add4_idle_busy", int'(bus.busy), 0);

        // MAT_SCAL_MUL, scalar 3, A = 2,5: results 6,15 with MUL_LAT timing, no B reads.
        amem[0] = 2;
        amem[1] = 5;
        do_start(3'd2, 2, 3);
        wait_done("mul2", 100);
        check_int("mul2_b_reads", b_q.size() - b0, 0);
        check_int("mul2_fu_count", fu_q.size() - f0, 2);
        check_int("mul2_fu_sel", int'(fu_q[f0].sel) + int'(fu_q[f0+1].sel), 2);
        check("mul2_fu_b", fu_q[f0].data, rep(3));
        check("mul2_wdata0", wr_q[w0].data, rep(6));
        check("mul2_wdata1", wr_q[w0+1].data, rep(15));
        check_int("mul2_waddr1", int'(wr_q[w0+1].addr), R_BASE + 1);
        check_int("mul2_wcyc0", wr_q[w0].cyc, s + 3 + MUL_LAT);
        check_int("mul2_done_cyc", done_q[d0], s + 5 + MUL_LAT);

        // Backpressure: 40 words of A*3 + 100, writes stalled for 30 cycles.
        for (int i = 0; i < 64; i++) amem[i] = 3 * i;
        bus.r_ready = 1'b0;
        do_start(3'd3, 40, 100);
        tick(29);
        check_int("bp_reads_stalled", rd_q.size() - rd0, 16);
        check_int("bp_no_writes", wr_q.size() - w0, 0);
        @(negedge clock);
        check_int("bp_wr_en_held", int'(bus.r_wr_en), 1);
        tick(1);
        bus.r_ready = 1'b1;
        wait_done("bp", 400);
        check_int("bp_reads_total", rd_q.size() - rd0, 40);
        check_int("bp_writes_total", wr_q.size() - w0, 40);
        for (int i = 0; i < 40; i++) begin
            check_int($sformatf("bp_waddr%0d", i), int'(wr_q[w0+i].addr), R_BASE + i);
            check($sformatf("bp_wdata%0d", i), wr_q[w0+i].data, rep(3 * i + 100));
        end
        check_int("bp_write_span", wr_q[w0+39].cyc - wr_q[w0].cyc, 39);
        check_int("bp_done_after_last", done_q[d0], wr_q[w0+39].cyc + 1);

        // Illegal opcode 5: err set, stays idle, then a legal start clears err.
        do_start(3'd5, 4, 0);
        tick(2);
        @(negedge clock);
        check_int("illegal_err", int'(bus.err), 1);
        check_int("illegal_busy", int'(bus.busy), 0);
        check_int("illegal_reads", rd_q.size() - rd0, 0);
        tick(1);
        do_start(3'd3, 1, 7);
        @(negedge clock);
        check_int("legal_err_cleared", int'(bus.err), 0);
        wait_done("one", 100);
        check("one_wdata", wr_q[w0].data, rep(7));
        check_int("one_done_cyc", done_q[d0], s + 4 + ADD_LAT);

        // num_words = 0: start high in cycle 1 gives done in cycle 2, no strobes.
        do_start(3'd1, 0, 0);
        tick(3);
        check_int("zero_done_cyc", done_q[d0], s + 1);
        check_int("zero_done_pulses", done_q.size() - d0, 1);
        check_int("zero_reads", (rd_q.size() - rd0) + (b_q.size() - b0), 0);
        check_int("zero_fu", fu_q.size() - f0, 0);
        check_int("zero_writes", wr_q.size() - w0, 0);

        // Reset during cycle 6 of a 20-word run: all outputs zero, then no further activity.
        do_start(3'd1, 20, 0);
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_all_zero("midreset");
        snap();
        tick(20);
        check_int("midreset_writes", wr_q.size() - w0, 0);
        check_int("midreset_reads", rd_q.size() - rd0, 0);
        check_int("midreset_done", done_q.size() - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mat_stream_engine.md
MAT_STREAM_ENGINE -- requirements
Module: mat_stream_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one element.
REQ-002 SHALL have parameter LANES, default 8, elements per memory word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 11, word-address width.
REQ-004 SHALL have parameters ADD_LAT, default 7, and MUL_LAT, default 5, which are the functional-unit latencies in cycles.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, result buffer depth; elaboration SHALL fail if FIFO_DEPTH < max(ADD_LAT,MUL_LAT)+2.
REQ-006 SHALL have parameters A_BASE, B_BASE, R_BASE, defaults 0, 512, 1024, which are operand and result base word addresses.
REQ-007 Ports (name, direction, width, meaning):
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run.
- op_code  in  3  1=MAT_ADD, 2=MAT_SCAL_MUL, 3=MAT_SCAL_ADD.
- num_words  in  ADDR_WIDTH  words to process.
- scalar  in  DATA_WIDTH  scalar operand.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal opcode flag.
- a_rd_en / b_rd_en  out  1  read strobes.
- a_addr / b_addr  out  ADDR_WIDTH  read addresses.
- a_rdata / b_rdata  in  LANES*DATA_WIDTH  read data, valid 1 cycle after strobe.
- fu_valid  out  1  operands valid.
- fu_sel  out  1  0=add, 1=mul.
- fu_a / fu_b  out  LANES*DATA_WIDTH  operands.
- fu_res  in  LANES*DATA_WIDTH  result.
- r_wr_en  out  1  write request.
- r_addr  out  ADDR_WIDTH  result address.
- r_wdata  out  LANES*DATA_WIDTH  result data.
- r_ready  in  1  write accepted.

Function
REQ-008 SHALL implement states IDLE, RUN, DONE.
REQ-009 IDLE: busy=0; on start=1 SHALL latch op_code, num_words and scalar; a legal op with num_words>0 goes to RUN.
REQ-010 Starting a run with an illegal op SHALL set err=1 (sticky until the next start) and remain in IDLE.
REQ-011 Starting a run with num_words=0 SHALL go to DONE with no memory access.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 RUN: SHALL issue one read per cycle when issued<num_words and (inflight+fifo_count)<FIFO_DEPTH, sampled at the start of the cycle; a same-cycle FIFO pop does not free a credit until the next cycle.
REQ-014 A read SHALL drive a_addr=A_BASE+issued and b_addr=B_BASE+issued; b_rd_en SHALL assert only for MAT_ADD.
REQ-015 SHALL assert fu_valid exactly 1 cycle after each read, with fu_a=a_rdata.
REQ-016 fu_b SHALL equal b_rdata for MAT_ADD, and scalar replicated to every lane otherwise.
REQ-017 fu_sel SHALL be 1 only for MAT_SCAL_MUL.
REQ-018 fu_res SHALL be captured into the FIFO exactly LAT cycles after the matching fu_valid, where LAT=MUL_LAT for MAT_SCAL_MUL and ADD_LAT otherwise; tracking SHALL use a valid shift register.
REQ-019 r_wr_en SHALL equal FIFO not-empty, with r_wdata as the FIFO head.
REQ-020 r_addr SHALL equal R_BASE+written; on r_wr_en & r_ready, pop the FIFO and increment written.
REQ-021 FIFO push and pop in the same cycle SHALL leave the count unchanged.
REQ-022 The FIFO SHALL never overflow; an overflow is a design error.
REQ-023 RUN SHALL go to DONE in the cycle written reaches num_words.
REQ-024 DONE: SHALL pulse done=1 for one cycle, then go to IDLE; busy=1 in RUN and DONE.
REQ-025 Counters SHALL be ADDR_WIDTH wide; no wrap is possible because issued ≤ num_words.
REQ-026 With r_ready=1, one word, MAT_ADD: start sampled at edge 0; read issued cycle 1; fu_valid cycle 2; FIFO push cycle 2+ADD_LAT; write cycle 3+ADD_LAT; done cycle 4+ADD_LAT.
REQ-027 Steady-state throughput SHALL be 1 word/cycle while r_ready=1.

Reset
REQ-028 On reset=1 at a clock edge, the state SHALL go to IDLE and all counters, the FIFO, the valid pipeline and err SHALL clear.
REQ-029 In the cycle after reset, busy, done, all rd_en, fu_valid and r_wr_en SHALL be 0, and all address and data outputs SHALL be 0.
REQ-030 Reset mid-run SHALL discard in-flight results; no write SHALL occur after reset unless a new start is given.

Verification
REQ-031 MAT_ADD, num_words=4, r_ready=1, bench FU is an integer add with ADD_LAT: A[i]=i, B[i]=10 → writes R_BASE..R_BASE+3 = 10,11,12,13 per lane on consecutive cycles; done at cycle 7+ADD_LAT.
REQ-032 MAT_SCAL_MUL, scalar=3, num_words=2, A=2,5 → fu_sel=1, b_rd_en never asserts, results 6,15, latency per MUL_LAT.
REQ-033 Backpressure: num_words=40 with r_ready=0 for 30 cycles → reads stop once inflight+count=16; no loss; all 40 written in order once r_ready=1.
REQ-034 op_code=5 → err=1, busy stays 0, no reads; a subsequent legal start clears err.
REQ-035 num_words=0 → done pulses at cycle 2 and no strobes assert.
REQ-036 Reset asserted mid-run at cycle 6 → next cycle all outputs are 0, and no r_wr_en appears for 20 cycles.
